if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction-fetch stage of the 16-bit pipelined CPU: owns the PC, runs a request/acknowledge handshake to instruction memory, and drives the IF/ID pipeline register's inputs (next PC, 16-bit instruction, write enable, flush). It honours hazard stalls from the hazard unit and branch/jump redirects from later stages. Delivered instructions are always in program order, and no instruction fetched before a redirect ever reaches ID.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- PCwrite_i  in  1  from hazard unit; 0 = stall IF and IF/ID.
- branch_i  in  1  taken branch/jump redirect; has priority over PCwrite_i.
- branch_target_i  in  16  redirect PC, sampled when branch_i=1.
- imem_req_o  out  1  instruction memory request.
- imem_addr_o  out  16  word address of the outstanding request.
- imem_ack_i  in  1  memory acknowledge; imem_data_i valid in the same cycle.
- imem_data_i  in  16  fetched instruction.
- next_PC_o  out  16  PC+1 of the delivered instruction, to IF/ID.
- instr_o  out  16  delivered instruction, to IF/ID.
- IFIDwrite_o  out  1  IF/ID load enable.
- IFIDflush_o  out  1  IF/ID clear (inserts an all-zero bubble).

## Operation
- Memory is word-addressed: sequential fetch is PC+1, 16-bit modulo (16'hFFFF -> 16'h0000).
- Registers: pc, addr_q (address presented to memory), hold_q (captured instruction), state.
- States: IDLE, FETCH, HOLD, DISCARD. imem_req_o = (state==FETCH or DISCARD). imem_addr_o = addr_q.
- valid = (FETCH and imem_ack_i) or HOLD. instr_o = HOLD ? hold_q : imem_data_i. next_PC_o = pc+1.
- The following priority rules apply every cycle while rst_n=1:
  - branch_i=1: IFIDwrite_o=0, IFIDflush_o=1, pc<=branch_target_i. From FETCH without ack, go to DISCARD. Otherwise go to FETCH, with addr_q<=branch_target_i.
  - Otherwise, PCwrite_i=1 and valid: IFIDwrite_o=1, pc<=pc+1, addr_q<=pc+1, go to FETCH (back-to-back fetch).
  - Otherwise, PCwrite_i=1 and not valid: IFIDflush_o=1 (bubble into ID). State is unchanged.
  - Otherwise, PCwrite_i=0: IFIDwrite_o=0 and IFIDflush_o=0, so IF/ID holds. A FETCH with ack goes to HOLD with hold_q<=imem_data_i and pc unchanged.
- IDLE -> FETCH unconditionally on the first edge after reset release.
- FETCH without ack: stay in FETCH. imem_req_o and imem_addr_o are held stable until ack.
- DISCARD: the request for the stale addr_q stays asserted until acknowledged. On ack, the data is dropped, addr_q<=pc, and the state goes to FETCH. A further branch_i in DISCARD updates pc only and stays in DISCARD. valid is 0 in DISCARD.
- The memory protocol is never aborted: a request, once asserted, stays asserted with the same address until ack.
- Reset values: state=IDLE, pc=addr_q=RESET_PC, hold_q=16'h0000.
- While rst_n=0, outputs are forced: imem_req_o=0, IFIDwrite_o=0, IFIDflush_o=0, instr_o=16'h0000, next_PC_o=RESET_PC+1, imem_addr_o=RESET_PC.
- Reset asserted mid-request drops the request immediately. No completion is required.

## Timing
- Zero-wait memory (ack in the same cycle as req): one instruction is delivered per cycle. Delivery happens in the cycle of ack, and IF/ID captures it on that edge.
- N-cycle memory latency: N-1 bubble cycles (IFIDflush_o=1) are inserted before each delivery, provided PCwrite_i=1.
- Redirect: with zero-wait memory, the first target instruction is delivered at the earliest in the cycle after branch_i. In DISCARD, add the remaining stale-ack latency plus the new fetch latency.
- IFIDwrite_o and IFIDflush_o are never both 1.
- All outputs are combinational from registered state plus PCwrite_i, branch_i and imem_ack_i/imem_data_i. There is no combinational path from PCwrite_i or branch_i to imem_req_o.

## Test plan
- Reset, RESET_PC=16'h0000, zero-wait memory, PCwrite_i=1: imem_req_o rises 1 cycle after release. Addresses 0,1,2,3 are fetched back-to-back, and next_PC_o reads 1,2,3,4 with IFIDwrite_o=1 in each cycle.
- 3-cycle ack latency: IFIDflush_o=1 for 2 cycles, then IFIDwrite_o=1 for 1 cycle. imem_addr_o stays stable throughout the wait.
- PCwrite_i=0 in the cycle of an ack with data 16'hA5C3: enter HOLD with no IF/ID activity. When PCwrite_i returns to 1, instr_o=16'hA5C3 and IFIDwrite_o=1 in that cycle, and the next request is to pc+1.
- branch_i=1 with target 16'h0040 while a request to 16'h0005 is waiting: the state goes to DISCARD, and req stays high at 16'h0005 until ack. The ack data is never written to IF/ID, and the next request is to 16'h0040.
- branch_i=1 and PCwrite_i=0 in the same cycle as an ack: IFIDflush_o=1, the data is discarded, and the next fetch is from the target. pc=16'hFFFF delivered: next_PC_o=16'h0000 and the next address is 16'h0000.
- rst_n asserted while in FETCH with an ack pending: outputs go to their reset values immediately. After release, fetching resumes from RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction-fetch stage: PC, imem handshake, IF/ID drive
//
// Owns the program counter and a single outstanding request to instruction
// memory. Fetched instructions go to the IF/ID register in program order.
// Hazard stalls are honoured. Branch/jump redirects squash any instruction
// fetched before the redirect.
//
// Ports:
//   clk_i            rising-edge clock
//   rst_n            asynchronous active-low reset
//   PCwrite_i        0 = stall IF and IF/ID (hazard unit)
//   branch_i         taken redirect, wins over PCwrite_i
//   branch_target_i  redirect PC, sampled when branch_i=1
//   imem_req_o       request to instruction memory
//   imem_addr_o      word address of the outstanding request
//   imem_ack_i       memory acknowledge, imem_data_i valid in the same cycle
//   imem_data_i      fetched instruction
//   next_PC_o        PC+1 of the delivered instruction
//   instr_o          delivered instruction
//   IFIDwrite_o      IF/ID load enable
//   IFIDflush_o      IF/ID clear (all-zero bubble)

module if_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        PCwrite_i,
    input  logic        branch_i,
    input  logic [15:0] branch_target_i,
    output logic        imem_req_o,
    output logic [15:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [15:0] imem_data_i,
    output logic [15:0] next_PC_o,
    output logic [15:0] instr_o,
    output logic        IFIDwrite_o,
    output logic        IFIDflush_o
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FETCH   = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;
    localparam logic [1:0] ST_DISCARD = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] hold_q, hold_d;
    logic [15:0] pc_inc;
    logic        in_fetch, in_hold, in_discard;
    logic        valid;
    logic        write_d, flush_d;

    assign pc_inc     = pc_q + 16'd1;
    assign in_fetch   = (state_q == ST_FETCH);
    assign in_hold    = (state_q == ST_HOLD);
    assign in_discard = (state_q == ST_DISCARD);

    // An instruction is available either straight from memory or from the
    // capture register filled during a stall.
    assign valid = (in_fetch && imem_ack_i) || in_hold;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        hold_d  = hold_q;
        write_d = 1'b0;
        flush_d = 1'b0;

        if (branch_i) begin
            flush_d = 1'b1;
            pc_d    = branch_target_i;
            if ((in_fetch || in_discard) && !imem_ack_i) begin
                // A request is still in flight and cannot be withdrawn.
                // Let it complete in DISCARD, then refetch from pc.
                state_d = ST_DISCARD;
            end else begin
                // No request is pending past this edge, so fetch the target
                // directly.
                state_d = ST_FETCH;
                addr_d  = branch_target_i;
            end
        end else if (PCwrite_i && valid) begin
            write_d = 1'b1;
            pc_d    = pc_inc;
            addr_d  = pc_inc;
            state_d = ST_FETCH;
        end else begin
            // No delivery this cycle. Bubble ID unless the hazard unit wants
            // IF/ID frozen.
            flush_d = PCwrite_i;
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_FETCH;
                end
                ST_FETCH: begin
                    // Reaching here with an ack implies PCwrite_i=0.
                    if (imem_ack_i) begin
                        state_d = ST_HOLD;
                        hold_d  = imem_data_i;
                    end
                end
                ST_DISCARD: begin
                    if (imem_ack_i) begin
                        addr_d  = pc_q;
                        state_d = ST_FETCH;
                    end
                end
                default: begin
                    // HOLD with PCwrite_i=0 keeps the captured instruction.
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            hold_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            hold_q  <= hold_d;
        end
    end

    // The request depends only on registered state. A stall or branch can
    // therefore never glitch or withdraw a request.
    assign imem_req_o  = rst_n && (in_fetch || in_discard);
    assign imem_addr_o = rst_n ? addr_q : RESET_PC;
    assign next_PC_o   = rst_n ? pc_inc : (RESET_PC + 16'd1);
    assign instr_o     = !rst_n ? 16'h0000 : (in_hold ? hold_q : imem_data_i);
    assign IFIDwrite_o = rst_n && write_d;
    assign IFIDflush_o = rst_n && flush_d;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - self-checking bench for if_fetch_unit

module tb_if_fetch_unit;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        PCwrite_i;
    logic        branch_i;
    logic [15:0] branch_target_i;
    logic        imem_req_o;
    logic [15:0] imem_addr_o;
    logic        imem_ack_i;
    logic [15:0] imem_data_i;
    logic [15:0] next_PC_o;
    logic [15:0] instr_o;
    logic        IFIDwrite_o;
    logic        IFIDflush_o;

    if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk_i           (clk_i),
        .rst_n           (rst_n),
        .PCwrite_i       (PCwrite_i),
        .branch_i        (branch_i),
        .branch_target_i (branch_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ack_i      (imem_ack_i),
        .imem_data_i     (imem_data_i),
        .next_PC_o       (next_PC_o),
        .instr_o         (instr_o),
        .IFIDwrite_o     (IFIDwrite_o),
        .IFIDflush_o     (IFIDflush_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    // Memory contents: a fixed bijective function of the address, with one
    // optionally patched word.
    logic        patch_en;
    logic [15:0] patch_addr;
    logic [15:0] patch_val;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (patch_en && a == patch_addr) return patch_val;
        return (a * 16'h9E37) ^ 16'h3C5A;
    endfunction

    // Memory responder and program-order reference state.
    int          lat_fixed;
    int          lat;
    int          cnt;
    int          stall_cnt;
    logic        prev_req;
    logic        prev_ack;
    logic [15:0] prev_addr;
    logic [15:0] exp_pc;

    logic        o_req, o_write, o_flush;
    logic [15:0] o_addr, o_instr, o_npc;

    task automatic reset_checks(input string tag);
        check({tag, "_req"},   16'(imem_req_o),  16'd0);
        check({tag, "_write"}, 16'(IFIDwrite_o), 16'd0);
        check({tag, "_flush"}, 16'(IFIDflush_o), 16'd0);
        check({tag, "_instr"}, instr_o,          16'h0000);
        check({tag, "_npc"},   next_PC_o,        RESET_PC + 16'd1);
        check({tag, "_addr"},  imem_addr_o,      RESET_PC);
    endtask

    // One clock cycle. Call at a falling edge. Returns at the next falling edge.
    task automatic step(input logic pcw, input logic br, input logic [15:0] tgt);
        logic ack;
        ack = 1'b0;
        if (prev_req && !prev_ack) begin
            check("req_hold",  16'(imem_req_o), 16'd1);
            check("addr_hold", imem_addr_o,     prev_addr);
        end
        if (imem_req_o) begin
            if (prev_req && !prev_ack) begin
                cnt++;
            end else begin
                cnt = 0;
                lat = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
            end
            ack = (cnt >= lat);
        end
        imem_ack_i      = ack;
        imem_data_i     = ack ? mem_word(imem_addr_o) : 16'($urandom);
        PCwrite_i       = pcw;
        branch_i        = br;
        branch_target_i = tgt;
        #1;
        o_req   = imem_req_o;
        o_addr  = imem_addr_o;
        o_write = IFIDwrite_o;
        o_flush = IFIDflush_o;
        o_instr = instr_o;
        o_npc   = next_PC_o;

        check("wr_fl_excl", 16'(o_write & o_flush), 16'd0);
        if (br) begin
            check("br_write", 16'(o_write), 16'd0);
            check("br_flush", 16'(o_flush), 16'd1);
        end else if (!pcw) begin
            check("stall_write", 16'(o_write), 16'd0);
            check("stall_flush", 16'(o_flush), 16'd0);
        end else begin
            check("write_or_bubble", 16'(o_write ^ o_flush), 16'd1);
        end
        if (o_write) begin
            check("instr",   o_instr, mem_word(exp_pc));
            check("next_pc", o_npc,   exp_pc + 16'd1);
            exp_pc = exp_pc + 16'd1;
        end
        if (br) exp_pc = tgt;
        if (o_write || br) stall_cnt = 0;
        else if (pcw) stall_cnt++;
        check("liveness", 16'(stall_cnt > 12), 16'd0);

        prev_req  = o_req;
        prev_ack  = ack;
        prev_addr = o_addr;
        @(negedge clk_i);
    endtask

    initial begin
        rst_n = 1'b0;
        PCwrite_i = 1'b0; branch_i = 1'b0; branch_target_i = 16'h0000;
        imem_ack_i = 1'b0; imem_data_i = 16'h0000;
        patch_en = 1'b0; patch_addr = 16'h0000; patch_val = 16'h0000;
        lat_fixed = 0; lat = 0; cnt = 0; stall_cnt = 0;
        prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 16'h0000;
        exp_pc = RESET_PC;

        @(negedge clk_i);
        #1;
        reset_checks("por");
        @(negedge clk_i);
        rst_n = 1'b1;

        // Zero-wait back-to-back fetch after reset release.
        step(1'b1, 1'b0, 16'h0000);
        check("idle_req", 16'(o_req), 16'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 16'h0000);
            check("zw_req",   16'(o_req),   16'd1);
            check("zw_addr",  o_addr,       16'(i));
            check("zw_write", 16'(o_write), 16'd1);
            check("zw_npc",   o_npc,        16'(i + 1));
        end

        // Three-cycle memory latency: two bubbles, then one delivery.
        lat_fixed = 2;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 16'h0000);
            check("lat_addr",  o_addr,       16'h0004);
            check("lat_write", 16'(o_write), 16'(i == 2));
            check("lat_flush", 16'(o_flush), 16'(i < 2));
        end

        // Branch while the request to 0x0005 is waiting.
        lat_fixed = 3;
        step(1'b1, 1'b0, 16'h0000);
        check("dis_addr0", o_addr, 16'h0005);
        step(1'b1, 1'b1, 16'h0040);
        check("dis_addr1", o_addr, 16'h0005);
        step(1'b1, 1'b0, 16'h0000);
        check("dis_req2",  16'(o_req), 16'd1);
        check("dis_addr2", o_addr,     16'h0005);
        step(1'b1, 1'b0, 16'h0000);
        check("dis_addr3", o_addr,       16'h0005);
        check("dis_drop",  16'(o_write), 16'd0);
        lat_fixed = 0;
        step(1'b1, 1'b0, 16'h0000);
        check("tgt_addr",  o_addr,       16'h0040);
        check("tgt_write", 16'(o_write), 16'd1);
        check("tgt_npc",   o_npc,        16'h0041);

        // Stall in the ack cycle: capture, hold, release.
        patch_en = 1'b1; patch_addr = 16'h0041; patch_val = 16'hA5C3;
        step(1'b0, 1'b0, 16'h0000);
        check("hold_ack_addr", o_addr,       16'h0041);
        check("hold_ack_wr",   16'(o_write), 16'd0);
        step(1'b0, 1'b0, 16'h0000);
        check("hold_req", 16'(o_req), 16'd0);
        step(1'b1, 1'b0, 16'h0000);
        check("hold_instr", o_instr,      16'hA5C3);
        check("hold_write", 16'(o_write), 16'd1);
        check("hold_npc",   o_npc,        16'h0042);
        step(1'b1, 1'b0, 16'h0000);
        check("hold_next_addr", o_addr, 16'h0042);
        patch_en = 1'b0;

        // Branch with stall in an ack cycle, then 0xFFFF wraps to 0x0000.
        step(1'b0, 1'b1, 16'hFFFF);
        check("bs_flush", 16'(o_flush), 16'd1);
        step(1'b1, 1'b0, 16'h0000);
        check("wrap_addr", o_addr, 16'hFFFF);
        check("wrap_npc",  o_npc,  16'h0000);
        step(1'b1, 1'b0, 16'h0000);
        check("wrap_next", o_addr, 16'h0000);

        // Reset asserted while a request is pending with an ack present.
        lat_fixed = 3;
        step(1'b1, 1'b0, 16'h0000);
        imem_ack_i = 1'b1; imem_data_i = 16'h1234; PCwrite_i = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        reset_checks("mid");
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n = 1'b1;
        prev_req = 1'b0; prev_ack = 1'b0; exp_pc = RESET_PC; stall_cnt = 0;
        lat_fixed = 0;
        step(1'b1, 1'b0, 16'h0000);
        check("rel_req", 16'(o_req), 16'd0);
        step(1'b1, 1'b0, 16'h0000);
        check("rel_addr",  o_addr,       RESET_PC);
        check("rel_write", 16'(o_write), 16'd1);

        // Random stalls, redirects and memory latency.
        lat_fixed = -1;
        for (int i = 0; i < 3000; i++) begin
            logic        pcw, br;
            logic [15:0] tgt;
            pcw = ($urandom_range(0, 9) < 8);
            br  = ($urandom_range(0, 9) == 0);
            tgt = ($urandom_range(0, 7) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1))
                                              : 16'($urandom);
            step(pcw, br, tgt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
